// File: rtl/ff_array_pkg.sv
// Shared types for the two-port flip-flop metadata array.
// Holds the bulk-clear sweep FSM encoding.
package ff_array_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } sweep_state_t;

endpackage

// File: rtl/ff_array_merge.sv
// Per-bit two-port write-mask merge with port 1 taking priority on overlapping bits.
// Used by the commit path for every entry and, through it, by the read bypass.
module ff_array_merge #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] mask0,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] mask1,
  input  logic [WIDTH-1:0] data1,
  output logic [WIDTH-1:0] merged
);

  assign merged = (mask1 & data1)
                | (~mask1 & mask0 & data0)
                | (~mask1 & ~mask0 & cur);

endmodule

// File: rtl/ff_array_2p.sv
// Two-port (R/W + W-only) flip-flop array for cache metadata with a bulk-clear sweep.
// Optional write-to-read bypass on port 0 is enabled by defining FF_ARRAY_2P_WR_FWD_EN.
module ff_array_2p
  import ff_array_pkg::*;
#(
  parameter int               S_INDEX   = 4,
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] CLR_VALUE = '0
) (
  input  logic               clk0,
  input  logic               rst0_n,
  input  logic               csb0,
  input  logic               web0,
  input  logic [S_INDEX-1:0] addr0,
  input  logic [WIDTH-1:0]   wmask0,
  input  logic [WIDTH-1:0]   din0,
  output logic [WIDTH-1:0]   dout0,
  input  logic               csb1,
  input  logic [S_INDEX-1:0] addr1,
  input  logic [WIDTH-1:0]   wmask1,
  input  logic [WIDTH-1:0]   din1,
  input  logic               clr,
  output logic               busy
);

  localparam int NUM_SETS = 1 << S_INDEX;

  // valid marks a write waiting to commit; port 0 also keeps addr as its read pointer.
  typedef struct packed {
    logic               valid;
    logic [S_INDEX-1:0] addr;
    logic [WIDTH-1:0]   mask;
    logic [WIDTH-1:0]   data;
  } wr_cmd_t;

  sweep_state_t       state;
  logic [S_INDEX-1:0] sweep_cnt;
  wr_cmd_t            cmd0;
  wr_cmd_t            cmd1;
  logic [WIDTH-1:0]   mem        [NUM_SETS];
  logic [WIDTH-1:0]   next_entry [NUM_SETS];

  for (genvar i = 0; i < NUM_SETS; i++) begin : g_entry
    logic hit0;
    logic hit1;

    assign hit0 = cmd0.valid && (cmd0.addr == S_INDEX'(i));
    assign hit1 = cmd1.valid && (cmd1.addr == S_INDEX'(i));

    ff_array_merge #(
      .WIDTH (WIDTH)
    ) u_merge (
      .cur    (mem[i]),
      .mask0  (hit0 ? cmd0.mask : '0),
      .data0  (cmd0.data),
      .mask1  (hit1 ? cmd1.mask : '0),
      .data1  (cmd1.data),
      .merged (next_entry[i])
    );
  end

`ifdef FF_ARRAY_2P_WR_FWD_EN
  // The merged next value already folds in both pending writes, so reading it is the bypass.
  assign dout0 = next_entry[cmd0.addr];
`else
  assign dout0 = mem[cmd0.addr];
`endif

  always_ff @(posedge clk0) begin
    if (!rst0_n) begin
      // NOTE: this is a flip-flop array, not SRAM, so every entry is reset explicitly.
      for (int i = 0; i < NUM_SETS; i++) begin
        mem[i] <= CLR_VALUE;
      end
      cmd0      <= '0;
      cmd1      <= '0;
      state     <= IDLE;
      sweep_cnt <= '0;
      busy      <= 1'b0;
    end else begin
      // NOTE: all state here uses non-blocking assignment; later writes to a field override earlier ones.
      unique case (state)
        IDLE: begin
          for (int i = 0; i < NUM_SETS; i++) begin
            mem[i] <= next_entry[i];
          end
          cmd0.valid <= 1'b0;
          cmd1.valid <= 1'b0;
          if (clr) begin
            state     <= SWEEP;
            sweep_cnt <= '0;
            busy      <= 1'b1;
          end else begin
            if (!csb0) begin
              cmd0 <= '{valid: !web0, addr: addr0, mask: wmask0, data: din0};
            end
            if (!csb1) begin
              cmd1 <= '{valid: 1'b1, addr: addr1, mask: wmask1, data: din1};
            end
          end
        end
        SWEEP: begin
          mem[sweep_cnt] <= CLR_VALUE;
          if (&sweep_cnt) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            sweep_cnt <= sweep_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
